// File: rtl/mul_hilo_ctrl_if.sv
// Handshake bundle between the EX-stage HI/LO sequencer and the multi-cycle multiplier.
interface mul_hilo_ctrl_if;
  logic        mul_signed_o;
  logic [31:0] mul_op1_o;
  logic [31:0] mul_op2_o;
  logic        mul_start_o;
  logic        mul_annul_o;
  logic [63:0] mul_result_i;
  logic        mul_ready_i;

  // sequencer side
  modport master (
    output mul_signed_o, mul_op1_o, mul_op2_o, mul_start_o, mul_annul_o,
    input  mul_result_i, mul_ready_i
  );

  // multiplier side
  modport slave (
    input  mul_signed_o, mul_op1_o, mul_op2_o, mul_start_o, mul_annul_o,
    output mul_result_i, mul_ready_i
  );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// EX-stage MULT/MULTU sequencer: drives the multiplier start/annul handshake,
// stalls the pipeline while the multiply is in flight, and owns HI/LO.
module mul_hilo_ctrl #(
  parameter int TIMEOUT_CYC = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mul_req_i,
  input  logic        ex_signed_i,
  input  logic [31:0] ex_op1_i,
  input  logic [31:0] ex_op2_i,
  input  logic        flush_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [31:0] hilo_wdata_i,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        err_o,
  mul_hilo_ctrl_if.master mul
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] CNT_LAST = 6'(TIMEOUT_CYC - 1);

  state_t      state, state_d;
  logic [5:0]  cnt;
  logic        start_q, start_d;
  logic        annul_q, annul_d;
  logic        signed_q;
  logic [31:0] op1_q, op2_q;
  logic        accept, prod_we, tmo;

  assign mul.mul_start_o  = start_q;
  assign mul.mul_annul_o  = annul_q;
  assign mul.mul_signed_o = signed_q;
  assign mul.mul_op1_o    = op1_q;
  assign mul.mul_op2_o    = op2_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state, stall and handshake decisions. Flush outranks ready, ready outranks timeout.
  always_comb begin
    state_d = state;
    stall_o = 1'b0;
    accept  = 1'b0;
    prod_we = 1'b0;
    tmo     = 1'b0;
    start_d = start_q;
    annul_d = 1'b0;
    case (state)
      IDLE: begin
        stall_o = ex_mul_req_i & ~flush_i;
        if (ex_mul_req_i && !flush_i) begin
          accept  = 1'b1;
          start_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          annul_d = 1'b1;
          start_d = 1'b0;
          state_d = DONE;
        end else if (mul.mul_ready_i) begin
          prod_we = 1'b1;
          start_d = 1'b0;
          state_d = DONE;
        end else if (cnt == CNT_LAST) begin
          tmo     = 1'b1;
          annul_d = 1'b1;
          start_d = 1'b0;
          state_d = DONE;
        end else begin
          stall_o = 1'b1;
        end
      end
      DONE: begin
        // One dead cycle so the multiplier sees start low; requests wait here.
        stall_o = ex_mul_req_i & ~flush_i;
        start_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Multiplier handshake registers, operand latch, BUSY counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q  <= 1'b0;
      annul_q  <= 1'b0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      cnt      <= '0;
      err_o    <= 1'b0;
    end else begin
      start_q <= start_d;
      annul_q <= annul_d;
      if (accept) begin
        signed_q <= ex_signed_i;
        op1_q    <= ex_op1_i;
        op2_q    <= ex_op2_i;
        cnt      <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 6'd1;
      end
      if (tmo) err_o <= 1'b1;
    end
  end

  // HI/LO: the retiring product is younger than any WB move, so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (prod_we) begin
      hi_o <= mul.mul_result_i[63:32];
      lo_o <= mul.mul_result_i[31:0];
    end else begin
      if (hi_we_i) hi_o <= hilo_wdata_i;
      if (lo_we_i) lo_o <= hilo_wdata_i;
    end
  end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl; the bench plays the multiplier by hand.
module tb_mul_hilo_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_mul_req_i = 1'b0;
  logic        ex_signed_i = 1'b0;
  logic [31:0] ex_op1_i = '0;
  logic [31:0] ex_op2_i = '0;
  logic        flush_i = 1'b0;
  logic        hi_we_i = 1'b0;
  logic        lo_we_i = 1'b0;
  logic [31:0] hilo_wdata_i = '0;
  logic        stall_o;
  logic [31:0] hi_o, lo_o;
  logic        err_o;

  int checks = 0;
  int failures = 0;

  mul_hilo_ctrl_if mif();

  mul_hilo_ctrl #(.TIMEOUT_CYC(63)) dut (
    .clk(clk), .rst(rst),
    .ex_mul_req_i(ex_mul_req_i), .ex_signed_i(ex_signed_i),
    .ex_op1_i(ex_op1_i), .ex_op2_i(ex_op2_i),
    .flush_i(flush_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i),
    .hilo_wdata_i(hilo_wdata_i),
    .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o), .err_o(err_o),
    .mul(mif)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after posedge; checks happen at +3.
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Plain MULT/MULTU handshake with the bench acting as multiplier; starts and ends in IDLE.
  task automatic run_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [63:0] res);
    ex_mul_req_i = 1'b1; ex_signed_i = sgn; ex_op1_i = a; ex_op2_i = b;
    tick;
    repeat (lat) tick;
    mif.mul_ready_i = 1'b1; mif.mul_result_i = res;
    tick;
    mif.mul_ready_i = 1'b0; mif.mul_result_i = '0; ex_mul_req_i = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    #1;
    checks++;
    if ({hi_o, lo_o} !== 64'h0) begin
      failures++; $display("FAIL reset_hilo got=%h exp=0", {hi_o, lo_o});
    end
    checks++;
    if ({err_o, mif.mul_start_o, mif.mul_annul_o, mif.mul_signed_o, stall_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {err_o, mif.mul_start_o, mif.mul_annul_o, mif.mul_signed_o, stall_o});
    end
    checks++;
    if ({mif.mul_op1_o, mif.mul_op2_o} !== 64'h0) begin
      failures++; $display("FAIL reset_ops got=%h exp=0", {mif.mul_op1_o, mif.mul_op2_o});
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_mult_signed;
    logic bad;
    ex_mul_req_i = 1'b1; ex_signed_i = 1'b1; ex_op1_i = 32'hFFFFFFFD; ex_op2_i = 32'h5;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      failures++; $display("FAIL sgn_stall_accept got=%b exp=1", stall_o);
    end
    tick;
    ex_op1_i = 32'h0; ex_op2_i = 32'h0; // operands must already be latched
    #1;
    checks++;
    if ({mif.mul_start_o, mif.mul_signed_o, mif.mul_op1_o, mif.mul_op2_o} !==
        {1'b1, 1'b1, 32'hFFFFFFFD, 32'h5}) begin
      failures++;
      $display("FAIL sgn_latch got=%b%b %h %h exp=11 fffffffd 00000005",
               mif.mul_start_o, mif.mul_signed_o, mif.mul_op1_o, mif.mul_op2_o);
    end
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (stall_o !== 1'b1 || mif.mul_start_o !== 1'b1) bad = 1'b1;
      tick; #1;
    end
    checks++;
    if (bad) begin
      failures++; $display("FAIL sgn_busy_stall got=dropped exp=held");
    end
    #1;
    mif.mul_ready_i = 1'b1; mif.mul_result_i = 64'hFFFFFFFF_FFFFFFF1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      failures++; $display("FAIL sgn_stall_ready got=%b exp=0", stall_o);
    end
    tick;
    mif.mul_ready_i = 1'b0; mif.mul_result_i = '0; ex_mul_req_i = 1'b0;
    #1;
    checks++;
    if ({hi_o, lo_o} !== 64'hFFFFFFFF_FFFFFFF1) begin
      failures++; $display("FAIL sgn_hilo got=%h exp=fffffffffffffff1", {hi_o, lo_o});
    end
    checks++;
    if ({mif.mul_start_o, mif.mul_annul_o, stall_o} !== 3'b000) begin
      failures++;
      $display("FAIL sgn_done got=%b exp=000", {mif.mul_start_o, mif.mul_annul_o, stall_o});
    end
    tick;
  endtask

  task automatic test_multu;
    run_mul(1'b0, 32'hFFFFFFFF, 32'h2, 2, 64'h00000001_FFFFFFFE);
    #1;
    checks++;
    if ({hi_o, lo_o, mif.mul_signed_o} !== {64'h00000001_FFFFFFFE, 1'b0}) begin
      failures++;
      $display("FAIL multu got=%h/%b exp=00000001fffffffe/0", {hi_o, lo_o}, mif.mul_signed_o);
    end
    run_mul(1'b1, 32'hFFFFFFFF, 32'h2, 1, 64'hFFFFFFFF_FFFFFFFE);
    #1;
    checks++;
    if ({hi_o, lo_o, mif.mul_signed_o} !== {64'hFFFFFFFF_FFFFFFFE, 1'b1}) begin
      failures++;
      $display("FAIL mult_neg got=%h/%b exp=fffffffffffffffe/1", {hi_o, lo_o}, mif.mul_signed_o);
    end
  endtask

  task automatic test_mthi_mtlo;
    hi_we_i = 1'b1; lo_we_i = 1'b1; hilo_wdata_i = 32'hAAAA5555;
    tick;
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    #1;
    checks++;
    if ({hi_o, lo_o} !== 64'hAAAA5555_AAAA5555) begin
      failures++; $display("FAIL mt_both got=%h exp=aaaa5555aaaa5555", {hi_o, lo_o});
    end
    hi_we_i = 1'b1; hilo_wdata_i = 32'h12345678;
    tick;
    hi_we_i = 1'b0; lo_we_i = 1'b1; hilo_wdata_i = 32'h9ABCDEF0;
    tick;
    lo_we_i = 1'b0; hilo_wdata_i = '0;
    #1;
    checks++;
    if ({hi_o, lo_o} !== 64'h12345678_9ABCDEF0) begin
      failures++; $display("FAIL mt_single got=%h exp=123456789abcdef0", {hi_o, lo_o});
    end
  endtask

  task automatic test_flush;
    // flush in IDLE blocks acceptance
    ex_mul_req_i = 1'b1; ex_signed_i = 1'b0; ex_op1_i = 32'h3; ex_op2_i = 32'h4; flush_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      failures++; $display("FAIL flush_idle_stall got=%b exp=0", stall_o);
    end
    tick;
    flush_i = 1'b0;
    #1;
    checks++;
    if (mif.mul_start_o !== 1'b0) begin
      failures++; $display("FAIL flush_idle_start got=%b exp=0", mif.mul_start_o);
    end
    // this cycle accepts; flush 10 cycles later
    tick;
    repeat (10) tick;
    flush_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b0) begin
      failures++; $display("FAIL flush_busy_stall got=%b exp=0", stall_o);
    end
    tick;
    flush_i = 1'b0; ex_mul_req_i = 1'b0;
    #1;
    checks++;
    if ({mif.mul_annul_o, mif.mul_start_o} !== 2'b10) begin
      failures++;
      $display("FAIL flush_annul got=%b exp=10", {mif.mul_annul_o, mif.mul_start_o});
    end
    tick;
    #1;
    checks++;
    if (mif.mul_annul_o !== 1'b0) begin
      failures++; $display("FAIL flush_annul_len got=%b exp=0", mif.mul_annul_o);
    end
    checks++;
    if ({hi_o, lo_o} !== 64'h12345678_9ABCDEF0) begin
      failures++; $display("FAIL flush_hilo got=%h exp=123456789abcdef0", {hi_o, lo_o});
    end
    #1;
    run_mul(1'b0, 32'h3, 32'h4, 3, 64'h0000000C);
    #1;
    checks++;
    if ({hi_o, lo_o, err_o} !== {64'h0000000C, 1'b0}) begin
      failures++; $display("FAIL flush_next got=%h/%b exp=000000000000000c/0", {hi_o, lo_o}, err_o);
    end
  endtask

  task automatic test_back_to_back;
    ex_mul_req_i = 1'b1; ex_signed_i = 1'b1; ex_op1_i = 32'h7; ex_op2_i = 32'h6;
    tick;
    mif.mul_ready_i = 1'b1; mif.mul_result_i = 64'h2A;
    tick; // now DONE
    mif.mul_ready_i = 1'b0; mif.mul_result_i = '0;
    ex_op1_i = 32'hFFFFFFFF; ex_op2_i = 32'hFFFFFFFF;
    #1;
    checks++;
    if ({stall_o, hi_o, lo_o} !== {1'b1, 64'h2A}) begin
      failures++; $display("FAIL b2b_done got=%b/%h exp=1/000000000000002a", stall_o, {hi_o, lo_o});
    end
    tick; // IDLE, not accepted in DONE
    #1;
    checks++;
    if ({mif.mul_start_o, stall_o} !== 2'b01) begin
      failures++; $display("FAIL b2b_wait got=%b exp=01", {mif.mul_start_o, stall_o});
    end
    tick; // accepted now
    #1;
    checks++;
    if ({mif.mul_start_o, mif.mul_op1_o, mif.mul_op2_o} !== {1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF}) begin
      failures++;
      $display("FAIL b2b_accept got=%b %h %h exp=1 ffffffff ffffffff",
               mif.mul_start_o, mif.mul_op1_o, mif.mul_op2_o);
    end
    #1;
    mif.mul_ready_i = 1'b1; mif.mul_result_i = 64'h1;
    tick;
    mif.mul_ready_i = 1'b0; mif.mul_result_i = '0; ex_mul_req_i = 1'b0;
    #1;
    checks++;
    if ({hi_o, lo_o} !== 64'h1) begin
      failures++; $display("FAIL b2b_hilo got=%h exp=0000000000000001", {hi_o, lo_o});
    end
    tick;
  endtask

  task automatic test_product_vs_mthi;
    ex_mul_req_i = 1'b1; ex_signed_i = 1'b0; ex_op1_i = 32'h1; ex_op2_i = 32'h1;
    tick;
    tick;
    mif.mul_ready_i = 1'b1; mif.mul_result_i = 64'h00000001_00000002;
    hi_we_i = 1'b1; hilo_wdata_i = 32'hDEADBEEF;
    tick;
    mif.mul_ready_i = 1'b0; mif.mul_result_i = '0; ex_mul_req_i = 1'b0;
    hi_we_i = 1'b0; hilo_wdata_i = '0;
    #1;
    checks++;
    if ({hi_o, lo_o} !== 64'h00000001_00000002) begin
      failures++; $display("FAIL prio_hilo got=%h exp=0000000100000002", {hi_o, lo_o});
    end
    tick;
  endtask

  task automatic test_timeout;
    logic bad;
    ex_mul_req_i = 1'b1; ex_signed_i = 1'b0; ex_op1_i = 32'h9; ex_op2_i = 32'h9;
    tick; // BUSY, cnt=0
    bad = 1'b0;
    for (int i = 0; i < 62; i++) begin
      #1;
      if (stall_o !== 1'b1 || err_o !== 1'b0) bad = 1'b1;
      tick;
    end
    #1;
    checks++;
    if (bad) begin
      failures++; $display("FAIL tmo_early got=released exp=stalled");
    end
    checks++;
    if ({stall_o, err_o} !== 2'b00) begin
      failures++; $display("FAIL tmo_last got=%b exp=00", {stall_o, err_o});
    end
    tick; // DONE
    ex_mul_req_i = 1'b0;
    #1;
    checks++;
    if ({err_o, mif.mul_annul_o, mif.mul_start_o} !== 3'b110) begin
      failures++;
      $display("FAIL tmo_abort got=%b exp=110", {err_o, mif.mul_annul_o, mif.mul_start_o});
    end
    tick; // IDLE
    #1;
    checks++;
    if ({err_o, mif.mul_annul_o} !== 2'b10) begin
      failures++; $display("FAIL tmo_sticky got=%b exp=10", {err_o, mif.mul_annul_o});
    end
    ex_mul_req_i = 1'b1;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      failures++; $display("FAIL tmo_idle_stall got=%b exp=1", stall_o);
    end
    tick;
    #1;
    checks++;
    if (mif.mul_start_o !== 1'b1) begin
      failures++; $display("FAIL tmo_reaccept got=%b exp=1", mif.mul_start_o);
    end
  endtask

  task automatic test_reset_midbusy;
    // still BUSY from the re-accept above
    rst = 1'b1; ex_mul_req_i = 1'b0;
    tick;
    rst = 1'b0;
    #1;
    checks++;
    if ({mif.mul_start_o, err_o, stall_o, hi_o, lo_o} !== 67'h0) begin
      failures++;
      $display("FAIL rst_busy got=%b%b%b %h exp=000 0", mif.mul_start_o, err_o, stall_o, {hi_o, lo_o});
    end
    run_mul(1'b1, 32'h2, 32'h3, 0, 64'h6);
    #1;
    checks++;
    if ({hi_o, lo_o} !== 64'h6) begin
      failures++; $display("FAIL rst_after got=%h exp=0000000000000006", {hi_o, lo_o});
    end
  endtask

  initial begin
    mif.mul_ready_i  = 1'b0;
    mif.mul_result_i = '0;
    test_reset;
    test_mult_signed;
    test_multu;
    test_mthi_mtlo;
    test_flush;
    test_back_to_back;
    test_product_vs_mthi;
    test_timeout;
    test_reset_midbusy;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
